// File: rtl/presc_pkg.sv
// Shared constants, per-channel state record and index-width helper for the
// prescaler bank.
package presc_pkg;

  localparam int CNT_W_DEF = 16;
  // State fields are sized for the widest supported counter; narrower
  // channels keep the upper bits at zero.
  localparam int CNT_W_MAX = 32;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] cnt;
    logic [CNT_W_MAX-1:0] div_act;
    logic [CNT_W_MAX-1:0] div_pend;
    logic                 pend;
  } presc_ch_st_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_presc_ch.sv
// One prescaler channel: counts to the active divisor, toggles its square
// output and swaps in a pending divisor only at safe (apply) points.
module mod_presc_ch
  import presc_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  localparam logic [CNT_W_MAX-1:0] DIV_RST_V = CNT_W_MAX'(CNT_W'(DIV_RST));

  presc_ch_st_t         st_q, st_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic                 toggle, apply;
  logic [CNT_W_MAX-1:0] ld_ext;

  assign ld_ext = CNT_W_MAX'(ld_div_i);
  assign toggle = en_i && !sync_i && (st_q.cnt == st_q.div_act);
  // Every point where the output phase restarts is safe for a divisor swap.
  assign apply  = !en_i || sync_i || toggle;

  always_comb begin
    st_d   = st_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (!en_i || sync_i) begin
      st_d.cnt = '0;
      clk_d    = 1'b0;
    end else if (toggle) begin
      st_d.cnt = '0;
      clk_d    = ~clk_q;
      tick_d   = 1'b1;
    end else begin
      st_d.cnt = st_q.cnt + 1'b1;
    end

    if (apply) begin
      if (ld_i) begin
        st_d.div_act  = ld_ext;
        st_d.div_pend = ld_ext;
      end else if (st_q.pend) begin
        st_d.div_act = st_q.div_pend;
      end
      st_d.pend = 1'b0;
    end else if (ld_i) begin
      st_d.div_pend = ld_ext;
      st_d.pend     = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q.cnt      <= '0;
      st_q.div_act  <= DIV_RST_V;
      st_q.div_pend <= DIV_RST_V;
      st_q.pend     <= 1'b0;
      clk_q         <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      st_q   <= st_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = st_q.pend;

endmodule

// File: rtl/mod_presc_bank.sv
// Bank of independent prescaler channels; decodes the load index and fans
// out sync and reset to every channel.
module mod_presc_bank
  import presc_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DIV_RST  = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CHANNELS-1:0]          en_i,
  input  logic                         ld_i,
  input  logic [idx_w(CHANNELS)-1:0]   ld_ch_i,
  input  logic [CNT_W-1:0]             ld_div_i,
  input  logic                         sync_i,
  output logic [CHANNELS-1:0]          clk_o,
  output logic [CHANNELS-1:0]          tick_o,
  output logic [CHANNELS-1:0]          pend_o
);

  localparam int LD_W = idx_w(CHANNELS);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    // Indices with no matching channel simply select nothing.
    logic ld_sel;
    assign ld_sel = ld_i && (ld_ch_i == LD_W'(n));

    mod_presc_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_i[n]),
      .sync_i   (sync_i),
      .ld_i     (ld_sel),
      .ld_div_i (ld_div_i),
      .clk_o    (clk_o[n]),
      .tick_o   (tick_o[n]),
      .pend_o   (pend_o[n])
    );
  end

endmodule

// File: tb/tb_mod_presc_bank.sv
// Directed bench for mod_presc_bank: a 4-channel main instance plus a
// 3-channel instance used to exercise out-of-range load indices.
module tb_mod_presc_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        ld;
  logic [1:0]  ld_ch;
  logic [15:0] ld_div;
  logic        sync;
  logic [3:0]  clk_o, tick_o, pend_o;

  logic [2:0]  en3;
  logic        ld3;
  logic [1:0]  ld_ch3;
  logic [2:0]  clk3, tick3, pend3;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mod_presc_bank #(.CHANNELS(4), .CNT_W(16), .DIV_RST(0)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .ld_i(ld), .ld_ch_i(ld_ch),
    .ld_div_i(ld_div), .sync_i(sync),
    .clk_o(clk_o), .tick_o(tick_o), .pend_o(pend_o)
  );

  mod_presc_bank #(.CHANNELS(3), .CNT_W(16), .DIV_RST(2)) dut3 (
    .clk_i(clk), .rst_i(rst), .en_i(en3), .ld_i(ld3), .ld_ch_i(ld_ch3),
    .ld_div_i(ld_div), .sync_i(sync),
    .clk_o(clk3), .tick_o(tick3), .pend_o(pend3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int dv[4];
    logic [3:0] e_clk, e_tick;
    dv[0] = 1; dv[1] = 2; dv[2] = 4; dv[3] = 7;
    rst = 1'b1; en = '0; ld = 1'b0; ld_ch = '0; ld_div = '0; sync = 1'b0;
    en3 = '0; ld3 = 1'b0; ld_ch3 = '0;

    // reset state
    step(); step();
    chk("rst_clk", clk_o, 0);
    chk("rst_tick", tick_o, 0);
    chk("rst_pend", pend_o, 0);

    // D = 0 on ch0: toggle every cycle
    rst = 1'b0; en = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("d0_clk0", clk_o[0], k % 2);
      chk("d0_tick0", tick_o[0], 1);
    end

    // load D=3 on disabled ch1: applied directly
    ld = 1'b1; ld_ch = 2'd1; ld_div = 16'd3;
    step();
    chk("ld_dis_pend1", pend_o[1], 0);
    ld = 1'b0; en = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("d3_clk1", clk_o[1], (k / 4) % 2);
      chk("d3_tick1", tick_o[1], (k % 4) == 0);
      chk("d3_pend1", pend_o[1], 0);
    end

    // load D=9 at cnt=1: pending for two cycles
    step();
    ld = 1'b1; ld_ch = 2'd1; ld_div = 16'd9;
    step();
    ld = 1'b0;
    chk("pend_a", pend_o[1], 1);
    chk("pend_a_clk1", clk_o[1], 1);
    step();
    chk("pend_b", pend_o[1], 1);
    chk("pend_b_clk1", clk_o[1], 1);
    step();
    chk("pend_clr", pend_o[1], 0);
    chk("old_half_clk1", clk_o[1], 0);
    chk("old_half_tick1", tick_o[1], 1);
    for (int k = 17; k <= 35; k++) begin
      step();
      chk("d9_clk1", clk_o[1], k >= 26);
      chk("d9_tick1", tick_o[1], k == 26);
    end

    // load coincident with toggle: new D=1 active at once
    ld = 1'b1; ld_ch = 2'd1; ld_div = 16'd1;
    step();
    ld = 1'b0;
    chk("coinc_pend1", pend_o[1], 0);
    chk("coinc_clk1", clk_o[1], 0);
    chk("coinc_tick1", tick_o[1], 1);
    step(); chk("d1_clk1_a", clk_o[1], 0);
    step(); chk("d1_clk1_b", clk_o[1], 1);
    step(); chk("d1_clk1_c", clk_o[1], 1);
    step(); chk("d1_clk1_d", clk_o[1], 0);

    // set D = 1,2,4,7, run out of phase, then sync
    for (int n = 0; n < 4; n++) begin
      ld = 1'b1; ld_ch = 2'(n); ld_div = 16'(dv[n]);
      step();
    end
    ld = 1'b0; en = 4'b1111;
    for (int k = 0; k < 7; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_clk", clk_o, 0);
    chk("sync_tick", tick_o, 0);
    chk("sync_pend", pend_o, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      for (int n = 0; n < 4; n++) begin
        e_clk[n]  = ((k / (dv[n] + 1)) % 2) == 1;
        e_tick[n] = (k % (dv[n] + 1)) == 0;
      end
      chk("post_sync_clk", clk_o, e_clk);
      chk("post_sync_tick", tick_o, e_tick);
    end

    // reset mid-period with a pending load, overriding ld and sync
    step();
    ld = 1'b1; ld_ch = 2'd3; ld_div = 16'd3;
    step();
    chk("pre_rst_pend3", pend_o[3], 1);
    rst = 1'b1; ld = 1'b1; ld_ch = 2'd0; ld_div = 16'd5; sync = 1'b1;
    step();
    chk("rst_mid_clk", clk_o, 0);
    chk("rst_mid_tick", tick_o, 0);
    chk("rst_mid_pend", pend_o, 0);
    rst = 1'b0; ld = 1'b0; sync = 1'b0;
    step(); chk("rst_d0_clk_a", clk_o, 4'b1111); chk("rst_d0_tick_a", tick_o, 4'b1111);
    step(); chk("rst_d0_clk_b", clk_o, 4'b0000); chk("rst_d0_tick_b", tick_o, 4'b1111);
    step(); chk("rst_d0_clk_c", clk_o, 4'b1111);

    // out-of-range index on the 3-channel bank (DIV_RST = 2)
    en3 = 3'b111;
    step();
    chk("b3_clk_a", clk3, 0);
    ld3 = 1'b1; ld_ch3 = 2'd3; ld_div = 16'd0;
    step();
    ld3 = 1'b0;
    chk("b3_oor_pend", pend3, 0);
    chk("b3_clk_b", clk3, 0);
    step(); chk("b3_clk_c", clk3, 3'b111); chk("b3_tick_c", tick3, 3'b111);
    step(); chk("b3_clk_d", clk3, 3'b111); chk("b3_tick_d", tick3, 3'b000);
    step(); chk("b3_clk_e", clk3, 3'b111);
    step(); chk("b3_clk_f", clk3, 3'b000); chk("b3_tick_f", tick3, 3'b111);
    chk("b3_pend_f", pend3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
